// File: rtl/csi_rx_lane_align_if.sv
// Lane-side bundle of the CSI-2 byte aligner: raw deserialiser bytes in, deskewed lane-coherent bytes out.
// master drives lane_en/deser_in (PHY side), slave is the aligner.
interface csi_rx_lane_align_if #(
   parameter int unsigned NUM_LANES = 2
);
   logic                   lane_en;
   logic [8*NUM_LANES-1:0] deser_in;
   logic [8*NUM_LANES-1:0] byte_out;
   logic                   byte_valid;
   logic                   aligned;
   logic [3*NUM_LANES-1:0] lane_offset;
   logic                   align_err;

   modport master (
      output lane_en, deser_in,
      input  byte_out, byte_valid, aligned, lane_offset, align_err
   );

   modport slave (
      input  lane_en, deser_in,
      output byte_out, byte_valid, aligned, lane_offset, align_err
   );
endinterface

// File: rtl/csi_rx_lane_align.sv
// Per-lane polarity fix, HS sync hunt with bit realignment, and FIFO deskew across D-PHY lanes.
// First byte 3 edges after sync completes in the window; no backpressure, skew beyond the FIFO raises align_err.
module csi_rx_lane_align #(
   parameter int unsigned NUM_LANES    = 2,
   parameter logic [3:0]  INVERT       = 4'b0,
   parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
   parameter int unsigned DESKEW_DEPTH = 4,
   parameter int unsigned HUNT_TIMEOUT = 64
) (
   input  logic               byte_clock,
   input  logic               reset_n,
   csi_rx_lane_align_if.slave bus
);
   localparam int unsigned AW       = $clog2(DESKEW_DEPTH);
   localparam logic [7:0]  CNT_LAST = 8'(HUNT_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, HUNT, LOCKED, ERR} state_e;

   state_e      state_q [NUM_LANES];
   state_e      state_d [NUM_LANES];
   logic [7:0]  curr_q  [NUM_LANES];
   logic [7:0]  prev_q  [NUM_LANES];
   logic [7:0]  cnt_q   [NUM_LANES];
   logic [7:0]  cnt_d   [NUM_LANES];
   logic [2:0]  off_q   [NUM_LANES];
   logic [2:0]  off_d   [NUM_LANES];
   logic [7:0]  mem_q   [NUM_LANES][DESKEW_DEPTH];
   logic [AW:0] wptr_q  [NUM_LANES];
   logic [AW:0] rptr_q  [NUM_LANES];

   logic [14:0] win     [NUM_LANES];
   logic        match   [NUM_LANES];
   logic [2:0]  mofs    [NUM_LANES];
   logic [7:0]  wbyte   [NUM_LANES];
   logic        full    [NUM_LANES];
   logic        empty   [NUM_LANES];
   logic        wr      [NUM_LANES];
   logic [8*NUM_LANES-1:0] heads;
   logic        all_locked, all_avail, any_err, ovf, rd_en, flush;

   logic [8*NUM_LANES-1:0] byte_out_q, byte_out_d;
   logic        byte_valid_q, byte_valid_d;
   logic        aligned_q, aligned_d;
   logic        err_q, err_d;

   // Bit 15 of {curr, prev} never feeds a candidate, so the window stops at bit 14.
   always_comb begin
      all_locked = 1'b1;
      all_avail  = 1'b1;
      any_err    = 1'b0;
      ovf        = 1'b0;
      heads      = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         win[i]   = {curr_q[i][6:0], prev_q[i]};
         match[i] = 1'b0;
         mofs[i]  = 3'd0;
         for (int o = 7; o >= 0; o--) begin
            if (win[i][o +: 8] == SYNC_BYTE) begin
               match[i] = 1'b1;
               mofs[i]  = 3'(o);
            end
         end
         wbyte[i] = win[i][off_q[i] +: 8];
         full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                    (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
         empty[i] = (wptr_q[i] == rptr_q[i]);
         heads[8*i +: 8] = mem_q[i][rptr_q[i][AW-1:0]];
         all_locked = all_locked && (state_q[i] == LOCKED);
         all_avail  = all_avail && !empty[i];
         any_err    = any_err || (state_q[i] == ERR);
      end
      rd_en = bus.lane_en && all_locked && all_avail;
      flush = !bus.lane_en || any_err;
      for (int i = 0; i < NUM_LANES; i++) begin
         wr[i] = (state_q[i] == LOCKED) && !flush && (!full[i] || rd_en);
         ovf   = ovf || ((state_q[i] == LOCKED) && full[i] && !rd_en);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         off_d[i]   = off_q[i];
         if (!bus.lane_en) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            off_d[i]   = '0;
         end else if (ovf) begin
            state_d[i] = ERR;
         end else begin
            case (state_q[i])
               IDLE: begin
                  state_d[i] = HUNT;
                  cnt_d[i]   = '0;
               end
               HUNT: begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
                  if (match[i]) begin
                     state_d[i] = LOCKED;
                     off_d[i]   = mofs[i];
                  end else if (cnt_q[i] == CNT_LAST) begin
                     state_d[i] = ERR;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      byte_valid_d = rd_en;
      byte_out_d   = rd_en ? heads : '0;
      aligned_d    = !flush && (aligned_q || rd_en);
      err_d        = bus.lane_en && (err_q || any_err);
   end

   always_ff @(posedge byte_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            state_q[i] <= IDLE;
            curr_q[i]  <= '0;
            prev_q[i]  <= '0;
            cnt_q[i]   <= '0;
            off_q[i]   <= '0;
            wptr_q[i]  <= '0;
            rptr_q[i]  <= '0;
         end
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         aligned_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            curr_q[i]  <= bus.deser_in[8*i +: 8] ^ {8{INVERT[i]}};
            prev_q[i]  <= curr_q[i];
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            off_q[i]   <= off_d[i];
            if (flush) begin
               wptr_q[i] <= '0;
               rptr_q[i] <= '0;
            end else begin
               if (wr[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
               if (rd_en) rptr_q[i] <= rptr_q[i] + 1'b1;
            end
         end
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         aligned_q    <= aligned_d;
         err_q        <= err_d;
      end
   end

   always_ff @(posedge byte_clock) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (wr[i]) mem_q[i][wptr_q[i][AW-1:0]] <= wbyte[i];
      end
   end

   always_comb begin
      bus.lane_offset = '0;
      for (int i = 0; i < NUM_LANES; i++) bus.lane_offset[3*i +: 3] = off_q[i];
   end

   assign bus.byte_out   = byte_out_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.aligned    = aligned_q;
   assign bus.align_err  = err_q;
endmodule

// File: tb/tb_csi_rx_lane_align.sv
// Directed bench for csi_rx_lane_align: 2 lanes, lane 1 pair swapped on board (INVERT=2'b10), depth 4.
module tb_csi_rx_lane_align;
   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   logic [127:0] lv, r0, r1;

   csi_rx_lane_align_if #(.NUM_LANES(2)) bus ();

   csi_rx_lane_align #(
      .NUM_LANES(2), .INVERT(4'b0010), .SYNC_BYTE(8'hB8),
      .DESKEW_DEPTH(4), .HUNT_TIMEOUT(64)
   ) dut (
      .byte_clock(clk),
      .reset_n   (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lane 1 carries the inverted line, so its raw bytes are complemented here.
   task automatic drive(input logic en, input logic [7:0] l0, input logic [7:0] l1);
      bus.lane_en  = en;
      bus.deser_in = {~l1, l0};
      tick();
   endtask

   task automatic drive_r(input int k);
      drive(1'b1, r0[8*k +: 8], r1[8*k +: 8]);
   endtask

   function automatic logic [7:0] g(input int k, input int s);
      if (k == s) return 8'hB8;
      if (k > s)  return 8'(k - s);
      return 8'h00;
   endfunction

   initial begin
      rst_n        = 1'b0;
      bus.lane_en  = 1'b0;
      bus.deser_in = '0;
      lv = '0;
      lv[24 +: 8] = 8'hB8;
      lv[32 +: 8] = 8'hA5;
      lv[40 +: 8] = 8'h5A;
      lv[48 +: 8] = 8'hC3;
      r0 = lv << 3;
      r1 = lv << 6;
      tick();
      tick();
      chk("rst_valid",   32'(bus.byte_valid),  32'h0);
      chk("rst_out",     32'(bus.byte_out),    32'h0);
      chk("rst_aligned", 32'(bus.aligned),     32'h0);
      chk("rst_err",     32'(bus.align_err),   32'h0);
      chk("rst_offset",  32'(bus.lane_offset), 32'h0);
      rst_n = 1'b1;

      // Offset 0: sync lies wholly in prev, so it completes on the edge after B8 is sampled.
      drive(1'b0, 8'h00, 8'h00);
      repeat (3) drive(1'b1, 8'h00, 8'h00);
      drive(1'b1, 8'hB8, 8'hB8);
      drive(1'b1, 8'h11, 8'h11);
      drive(1'b1, 8'h22, 8'h22);
      drive(1'b1, 8'h33, 8'h33);
      chk("t1_valid_early", 32'(bus.byte_valid), 32'h0);
      drive(1'b1, 8'h44, 8'h44);
      chk("t1_valid",   32'(bus.byte_valid),  32'h1);
      chk("t1_out0",    32'(bus.byte_out),    32'h1111);
      chk("t1_aligned", 32'(bus.aligned),     32'h1);
      chk("t1_offset",  32'(bus.lane_offset), 32'h0);
      drive(1'b1, 8'h55, 8'h55);
      chk("t1_out1", 32'(bus.byte_out), 32'h2222);
      drive(1'b1, 8'h66, 8'h66);
      chk("t1_out2", 32'(bus.byte_out), 32'h3333);
      chk("t1_valid_steady", 32'(bus.byte_valid), 32'h1);
      drive(1'b0, 8'h77, 8'h77);
      chk("t1_drop_valid",   32'(bus.byte_valid), 32'h0);
      chk("t1_drop_aligned", 32'(bus.aligned),    32'h0);
      chk("t1_drop_out",     32'(bus.byte_out),   32'h0);
      drive(1'b0, 8'h00, 8'h00);
      drive(1'b0, 8'h00, 8'h00);

      // Lane 0 shifted 3 bits, lane 1 shifted 6 bits; sync completes when raw byte 4 is sampled.
      for (int k = 0; k <= 6; k++) drive_r(k);
      chk("t2_valid_early", 32'(bus.byte_valid), 32'h0);
      drive_r(7);
      chk("t2_valid",  32'(bus.byte_valid),  32'h1);
      chk("t2_out0",   32'(bus.byte_out),    32'hA5A5);
      chk("t2_offset", 32'(bus.lane_offset), 32'h33);
      drive_r(8);
      chk("t2_out1", 32'(bus.byte_out), 32'h5A5A);
      drive_r(9);
      chk("t2_out2", 32'(bus.byte_out), 32'hC3C3);
      drive(1'b0, 8'h00, 8'h00);
      chk("t2_drop_offset", 32'(bus.lane_offset), 32'h0);
      chk("t2_drop_valid",  32'(bus.byte_valid),  32'h0);
      drive(1'b0, 8'h00, 8'h00);

      // Lane 1 locks 3 cycles after lane 0: fits exactly in the 4-deep FIFO.
      for (int k = 0; k <= 9; k++) drive(1'b1, g(k, 3), g(k, 6));
      chk("t3_valid_early", 32'(bus.byte_valid), 32'h0);
      drive(1'b1, g(10, 3), g(10, 6));
      chk("t3_valid", 32'(bus.byte_valid), 32'h1);
      chk("t3_out0",  32'(bus.byte_out),   32'h0101);
      drive(1'b1, g(11, 3), g(11, 6));
      chk("t3_out1", 32'(bus.byte_out), 32'h0202);
      drive(1'b1, g(12, 3), g(12, 6));
      chk("t3_out2", 32'(bus.byte_out),  32'h0303);
      chk("t3_err",  32'(bus.align_err), 32'h0);
      drive(1'b0, 8'h00, 8'h00);
      drive(1'b0, 8'h00, 8'h00);

      // Skew of 4 cycles overflows lane 0's FIFO while lane 1 has nothing yet.
      for (int k = 0; k <= 10; k++) drive(1'b1, g(k, 3), g(k, 7));
      chk("t3b_valid_pre", 32'(bus.byte_valid), 32'h0);
      chk("t3b_err_pre",   32'(bus.align_err),  32'h0);
      drive(1'b1, g(11, 3), g(11, 7));
      chk("t3b_err",     32'(bus.align_err),  32'h1);
      chk("t3b_valid",   32'(bus.byte_valid), 32'h0);
      chk("t3b_aligned", 32'(bus.aligned),    32'h0);
      drive(1'b1, g(12, 3), g(12, 7));
      chk("t3b_err_sticky",   32'(bus.align_err),  32'h1);
      chk("t3b_valid_sticky", 32'(bus.byte_valid), 32'h0);
      drive(1'b0, 8'h00, 8'h00);
      chk("t3b_err_clear", 32'(bus.align_err), 32'h0);
      drive(1'b0, 8'h00, 8'h00);

      // Hunt timeout: HUNT is entered one edge after lane_en rises, ERR after 64 hunt cycles.
      repeat (65) drive(1'b1, 8'h00, 8'h00);
      chk("t4_err_pre", 32'(bus.align_err), 32'h0);
      drive(1'b1, 8'h00, 8'h00);
      chk("t4_err", 32'(bus.align_err), 32'h1);
      drive(1'b0, 8'h00, 8'h00);
      chk("t4_err_clear", 32'(bus.align_err), 32'h0);
      drive(1'b0, 8'h00, 8'h00);

      // lane_en drops while lane 0 is locked and lane 1 is still hunting.
      for (int k = 0; k <= 6; k++) drive(1'b1, r0[8*k +: 8], 8'h00);
      chk("t6_offset_locked", 32'(bus.lane_offset), 32'h3);
      drive(1'b0, 8'h00, 8'h00);
      chk("t6_drop_offset",  32'(bus.lane_offset), 32'h0);
      chk("t6_drop_valid",   32'(bus.byte_valid),  32'h0);
      chk("t6_drop_aligned", 32'(bus.aligned),     32'h0);
      chk("t6_drop_err",     32'(bus.align_err),   32'h0);
      drive(1'b0, 8'h00, 8'h00);
      for (int k = 0; k <= 7; k++) drive_r(k);
      chk("t6_relock_out",    32'(bus.byte_out),    32'hA5A5);
      chk("t6_relock_offset", 32'(bus.lane_offset), 32'h33);
      drive_r(8);

      // Asynchronous reset in the middle of a valid burst.
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid",   32'(bus.byte_valid),  32'h0);
      chk("t6_rst_out",     32'(bus.byte_out),    32'h0);
      chk("t6_rst_aligned", 32'(bus.aligned),     32'h0);
      chk("t6_rst_offset",  32'(bus.lane_offset), 32'h0);
      bus.lane_en  = 1'b0;
      bus.deser_in = '0;
      tick();
      rst_n = 1'b1;
      drive(1'b0, 8'h00, 8'h00);
      repeat (2) drive(1'b1, 8'h00, 8'h00);
      drive(1'b1, 8'hB8, 8'hB8);
      drive(1'b1, 8'h61, 8'h61);
      drive(1'b1, 8'h62, 8'h62);
      drive(1'b1, 8'h63, 8'h63);
      drive(1'b1, 8'h64, 8'h64);
      chk("t6_fresh_valid", 32'(bus.byte_valid), 32'h1);
      chk("t6_fresh_out",   32'(bus.byte_out),   32'h6161);
      drive(1'b0, 8'h00, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
